// File: rtl/pool2d_engine.sv
// rtl/pool2d_engine.sv - 2x2 stride-2 avg/max pooling engine; optional POOL_RELU_EN clamps results to >= 0
module pool2d_engine #(
  parameter int CHANNELS = 16,
  parameter int IN_H     = 10,
  parameter int IN_W     = 10,
  parameter int DATA_W   = 8,
  localparam int OH      = IN_H / 2,
  localparam int OW      = IN_W / 2,
  localparam int IN_AW   = $clog2(CHANNELS * IN_H * IN_W),
  localparam int OUT_AW  = $clog2(CHANNELS * OH * OW)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     mode,
  output logic                     busy,
  output logic                     done,
  output logic                     in_rd_en,
  output logic [IN_AW-1:0]         in_rd_addr,
  input  logic signed [DATA_W-1:0] in_rd_data,
  output logic                     out_wr_en,
  output logic [OUT_AW-1:0]        out_wr_addr,
  output logic signed [DATA_W-1:0] out_wr_data
);

  localparam int CH_W = $clog2(CHANNELS + 1);
  localparam int R_W  = $clog2(OH + 1);
  localparam int C_W  = $clog2(OW + 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);
  localparam logic [R_W-1:0]  R_LAST  = R_W'(OH - 1);
  localparam logic [C_W-1:0]  C_LAST  = C_W'(OW - 1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_FINAL, S_WRITE, S_DONE} state_t;

  state_t                     state;
  logic [1:0]                 k;
  logic [CH_W-1:0]            ch, nch;
  logic [R_W-1:0]             r, nr;
  logic [C_W-1:0]             c, nc;
  logic                       last;
  logic                       mode_q;
  logic signed [DATA_W+1:0]   acc, d_ext, sum;
  logic signed [DATA_W-1:0]   mx, mx_new, result;

  // Tap k of window (ch,r,c): k[1] selects the lower row, k[0] the right column.
  function automatic logic [IN_AW-1:0] rd_addr(input logic [CH_W-1:0] fch, input logic [R_W-1:0] fr,
                                               input logic [C_W-1:0] fc, input logic [1:0] fk);
    int a;
    a = int'(fch) * IN_H * IN_W + (2 * int'(fr) + int'(fk[1])) * IN_W + 2 * int'(fc) + int'(fk[0]);
    return IN_AW'(a);
  endfunction

  function automatic logic [OUT_AW-1:0] wr_addr(input logic [CH_W-1:0] fch, input logic [R_W-1:0] fr,
                                                input logic [C_W-1:0] fc);
    int a;
    a = int'(fch) * OH * OW + int'(fr) * OW + int'(fc);
    return OUT_AW'(a);
  endfunction

  // Next window position: column fastest, then row, then channel.
  always_comb begin
    nch  = ch;
    nr   = r;
    nc   = c;
    last = (ch == CH_LAST) && (r == R_LAST) && (c == C_LAST);
    if (c != C_LAST) begin
      nc = c + 1'b1;
    end else begin
      nc = '0;
      if (r != R_LAST) begin
        nr = r + 1'b1;
      end else begin
        nr  = '0;
        nch = ch + 1'b1;
      end
    end
  end

  // Combine the returning datum with the running sum/max and form the pooled value.
  always_comb begin
    d_ext  = {{2{in_rd_data[DATA_W-1]}}, in_rd_data};
    sum    = acc + d_ext;
    mx_new = (in_rd_data > mx) ? in_rd_data : mx;
    result = mode_q ? mx_new : DATA_W'(sum >>> 2);
`ifdef POOL_RELU_EN
    if (result[DATA_W-1]) result = '0;
`endif
  end

  // Window sequencer: 4 reads, one absorb/compute cycle, one write per window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      in_rd_en    <= 1'b0;
      in_rd_addr  <= '0;
      out_wr_en   <= 1'b0;
      out_wr_addr <= '0;
      out_wr_data <= '0;
      k           <= '0;
      ch          <= '0;
      r           <= '0;
      c           <= '0;
      mode_q      <= 1'b0;
      acc         <= '0;
      mx          <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q     <= mode;
            ch         <= '0;
            r          <= '0;
            c          <= '0;
            k          <= '0;
            busy       <= 1'b1;
            in_rd_en   <= 1'b1;
            in_rd_addr <= '0;
            state      <= S_READ;
          end
        end
        S_READ: begin
          // Data for tap k-1 arrives while tap k is being requested.
          if (k == 2'd1) begin
            acc <= d_ext;
            mx  <= in_rd_data;
          end else if (k != 2'd0) begin
            acc <= sum;
            mx  <= mx_new;
          end
          if (k == 2'd3) begin
            in_rd_en <= 1'b0;
            state    <= S_FINAL;
          end else begin
            k          <= k + 2'd1;
            in_rd_addr <= rd_addr(ch, r, c, k + 2'd1);
          end
        end
        S_FINAL: begin
          out_wr_en   <= 1'b1;
          out_wr_addr <= wr_addr(ch, r, c);
          out_wr_data <= result;
          state       <= S_WRITE;
        end
        S_WRITE: begin
          out_wr_en <= 1'b0;
          if (last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            ch         <= nch;
            r          <= nr;
            c          <= nc;
            k          <= '0;
            in_rd_en   <= 1'b1;
            in_rd_addr <= rd_addr(nch, nr, nc, 2'd0);
            state      <= S_READ;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool2d_engine.sv
// tb/tb_pool2d_engine.sv - randomized self-checking bench for pool2d_engine (default and 2x5x5 instances)
module tb_pool2d_engine;

`ifdef POOL_RELU_EN
  localparam int EXP_AVG_NEG = 0;
  localparam int EXP_MAX_NEG = 0;
`else
  localparam int EXP_AVG_NEG = -3;
  localparam int EXP_MAX_NEG = -128;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Default instance: 16 x 10 x 10
  logic               a_start = 1'b0, a_mode = 1'b0;
  logic               a_busy, a_done, a_rd_en, a_wr_en;
  logic [10:0]        a_rd_addr;
  logic [8:0]         a_wr_addr;
  logic signed [7:0]  a_rd_data = '0;
  logic signed [7:0]  a_wr_data;
  logic signed [7:0]  mem_a [0:1599];
  logic signed [7:0]  out_a [0:399];
  int                 a_wrs = 0;

  // Small odd-sized instance: 2 x 5 x 5
  logic               b_start = 1'b0, b_mode = 1'b0;
  logic               b_busy, b_done, b_rd_en, b_wr_en;
  logic [5:0]         b_rd_addr;
  logic [2:0]         b_wr_addr;
  logic signed [7:0]  b_rd_data = '0;
  logic signed [7:0]  b_wr_data;
  logic signed [7:0]  mem_b [0:49];
  logic signed [7:0]  out_b [0:7];
  int                 b_wrs = 0;
  int                 b_bad = 0;

  int n_checks = 0;
  int n_pass = 0;

  pool2d_engine u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .mode(a_mode), .busy(a_busy), .done(a_done),
    .in_rd_en(a_rd_en), .in_rd_addr(a_rd_addr), .in_rd_data(a_rd_data),
    .out_wr_en(a_wr_en), .out_wr_addr(a_wr_addr), .out_wr_data(a_wr_data)
  );

  pool2d_engine #(.CHANNELS(2), .IN_H(5), .IN_W(5), .DATA_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .mode(b_mode), .busy(b_busy), .done(b_done),
    .in_rd_en(b_rd_en), .in_rd_addr(b_rd_addr), .in_rd_data(b_rd_data),
    .out_wr_en(b_wr_en), .out_wr_addr(b_wr_addr), .out_wr_data(b_wr_data)
  );

  always #5 clk = ~clk;

  // Synchronous-read activation buffers and output capture
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= mem_a[a_rd_addr];
    if (b_rd_en) b_rd_data <= mem_b[b_rd_addr];
    if (a_wr_en) begin
      out_a[a_wr_addr] <= a_wr_data;
      a_wrs = a_wrs + 1;
    end
    if (b_wr_en) begin
      out_b[b_wr_addr] <= b_wr_data;
      b_wrs = b_wrs + 1;
    end
    if (b_rd_en && (((int'(b_rd_addr) % 25) / 5 == 4) || (int'(b_rd_addr) % 5 == 4))) b_bad = b_bad + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int pool_ref(input int v0, input int v1, input int v2, input int v3, input bit m);
    int s;
    int e;
    if (m) begin
      e = v0;
      if (v1 > e) e = v1;
      if (v2 > e) e = v2;
      if (v3 > e) e = v3;
    end else begin
      s = v0 + v1 + v2 + v3;
      e = (s >= 0) ? s / 4 : -((-s + 3) / 4);
    end
`ifdef POOL_RELU_EN
    if (e < 0) e = 0;
`endif
    return e;
  endfunction

  function automatic int get_in(input bit which, input int i);
    return which ? int'(mem_b[i]) : int'(mem_a[i]);
  endfunction

  function automatic int get_out(input bit which, input int i);
    return which ? int'(out_b[i]) : int'(out_a[i]);
  endfunction

  task automatic fill(input bit which);
    if (which) for (int i = 0; i < 50; i++) mem_b[i] = 8'($urandom);
    else for (int i = 0; i < 1600; i++) mem_a[i] = 8'($urandom);
  endtask

  task automatic set_win(input int ch, input int r, input int c, input int v0, input int v1, input int v2, input int v3);
    int base;
    base = ch * 100 + 2 * r * 10 + 2 * c;
    mem_a[base]      = 8'(v0);
    mem_a[base + 1]  = 8'(v1);
    mem_a[base + 10] = 8'(v2);
    mem_a[base + 11] = 8'(v3);
  endtask

  task automatic check_model(input bit which, input bit m, input string tag);
    int nch, h, w, oh, ow, base, e;
    nch = which ? 2 : 16;
    h = which ? 5 : 10;
    w = h;
    oh = h / 2;
    ow = w / 2;
    for (int ch = 0; ch < nch; ch++)
      for (int r = 0; r < oh; r++)
        for (int c = 0; c < ow; c++) begin
          base = ch * h * w + 2 * r * w + 2 * c;
          e = pool_ref(get_in(which, base), get_in(which, base + 1),
                       get_in(which, base + w), get_in(which, base + w + 1), m);
          check(tag, get_out(which, ch * oh * ow + r * ow + c), e);
        end
  endtask

  task automatic drive_start(input bit which, input bit s, input bit m);
    if (which) begin b_start = s; b_mode = m; end
    else begin a_start = s; a_mode = m; end
  endtask

  task automatic run_pass(input bit which, input bit m, input int inject, input bit start_at_done, output int lat);
    @(negedge clk);
    drive_start(which, 1'b1, m);
    @(negedge clk);
    drive_start(which, 1'b0, m);
    lat = 1;
    check("busy_rise", which ? b_busy : a_busy, 1);
    check("first_rd_en", which ? b_rd_en : a_rd_en, 1);
    check("first_rd_addr", which ? int'(b_rd_addr) : int'(a_rd_addr), 0);
    while (!(which ? b_done : a_done) && lat < 3000) begin
      @(negedge clk);
      lat++;
      if (lat == inject) drive_start(which, 1'b1, ~m);
      else if (lat == inject + 1) drive_start(which, 1'b0, m);
    end
    check("done_seen", which ? b_done : a_done, 1);
    check("busy_low_at_done", which ? b_busy : a_busy, 0);
    if (start_at_done) begin
      drive_start(which, 1'b1, m);
      @(negedge clk);
      drive_start(which, 1'b0, m);
      check("start_at_done_ignored_busy", which ? b_busy : a_busy, 0);
      check("start_at_done_ignored_rd", which ? b_rd_en : a_rd_en, 0);
    end
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int snap;

    repeat (3) @(negedge clk);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_rd_en", a_rd_en, 0);
    check("rst_wr_en", a_wr_en, 0);
    check("rst_rd_addr", int'(a_rd_addr), 0);
    check("rst_wr_addr", int'(a_wr_addr), 0);
    check("rst_wr_data", int'(a_wr_data), 0);
    check("rst_b_busy", b_busy, 0);
    rst_n = 1'b1;

    // Odd-sized map: last row/column must never be read
    for (int m = 0; m < 2; m++) begin
      fill(1'b1);
      snap = b_wrs;
      run_pass(1'b1, 1'(m), -5, 1'b0, lat);
      check("b_latency", lat, 49);
      check("b_writes", b_wrs - snap, 8);
      check_model(1'b1, 1'(m), m ? "b_max" : "b_avg");
    end
    check("b_row4_col4_unread", b_bad, 0);

    // Default map, average mode, with start issued in the done cycle
    fill(1'b0);
    set_win(0, 0, 0, 4, 5, 6, 7);
    set_win(0, 0, 1, -1, -2, -3, -4);
    snap = a_wrs;
    run_pass(1'b0, 1'b0, -5, 1'b1, lat);
    check("a_avg_latency", lat, 2401);
    check("a_avg_writes", a_wrs - snap, 400);
    check("avg_4567", int'(out_a[0]), 5);
    check("avg_neg_floor", int'(out_a[1]), EXP_AVG_NEG);
    check_model(1'b0, 1'b0, "a_avg");

    // Default map, max mode, with a mode-flipped start injected mid-pass
    fill(1'b0);
    set_win(0, 0, 0, -128, -1, 5, 3);
    set_win(0, 0, 1, -128, -128, -128, -128);
    set_win(0, 0, 2, 2, -5, 1, 0);
    snap = a_wrs;
    run_pass(1'b0, 1'b1, 777, 1'b0, lat);
    check("a_max_latency", lat, 2401);
    check("a_max_writes", a_wrs - snap, 400);
    check("max_mixed", int'(out_a[0]), 5);
    check("max_all_min", int'(out_a[1]), EXP_MAX_NEG);
    check("max_2n510", int'(out_a[2]), 2);
    check_model(1'b0, 1'b1, "a_max");

    // Reset asserted mid-pass
    fill(1'b0);
    @(negedge clk);
    drive_start(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive_start(1'b0, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    snap = a_wrs;
    check("abort_busy", a_busy, 0);
    check("abort_rd_en", a_rd_en, 0);
    check("abort_wr_en", a_wr_en, 0);
    check("abort_rd_addr", int'(a_rd_addr), 0);
    check("abort_wr_addr", int'(a_wr_addr), 0);
    check("abort_wr_data", int'(a_wr_data), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("no_write_after_abort", a_wrs - snap, 0);
    check("idle_after_abort", a_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
